// File: rtl/better_neighbor_writer.sv
// Builds the better-neighbor table in node memory: every offered neighbor whose Q-value beats
// the latched best goes to consecutive slots, then the entry count is written once.
module better_neighbor_writer #(
   parameter int                    WORD_WIDTH  = 16,
   parameter logic [WORD_WIDTH-1:0] TABLE_BASE  = 16'h668,
   parameter logic [WORD_WIDTH-1:0] COUNT_ADDR  = 16'h68C,
   parameter int                    ADDR_STRIDE = 2,
   parameter int                    MAX_ENTRIES = 18
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  logic                  start_collect,
   input  logic [WORD_WIDTH-1:0] mybest,
   input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
   input  logic [WORD_WIDTH-1:0] nbr_id,
   input  logic [WORD_WIDTH-1:0] nbr_qvalue,
   input  logic                  nbr_valid,
   input  logic                  nbr_last,
   output logic                  nbr_ready,
   output logic [WORD_WIDTH-1:0] address,
   output logic [WORD_WIDTH-1:0] data_out,
   output logic                  wr_en,
   output logic [WORD_WIDTH-1:0] count,
   output logic                  overflow,
   output logic                  done,
   output logic [7:0]            cstate
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      COLLECT     = 2'd1,
      WRITE_COUNT = 2'd2,
      DONE        = 2'd3
   } state_t;

   localparam logic [WORD_WIDTH-1:0] MAX_CNT  = WORD_WIDTH'(MAX_ENTRIES);
   localparam logic [WORD_WIDTH-1:0] STRIDE_W = WORD_WIDTH'(ADDR_STRIDE);
   localparam logic [WORD_WIDTH-1:0] ONE      = WORD_WIDTH'(1);

   state_t                state;
   logic [WORD_WIDTH-1:0] mybest_q;
   logic                  qualify;

   assign nbr_ready = (state == COLLECT);
   assign cstate    = {6'b0, state};

   // Strictly-lower Q is better; our own ID never enters the table.
   assign qualify = (nbr_qvalue < mybest_q) && (nbr_id != MY_NODE_ID);

   // NOTE: every register here is state, so all updates are non-blocking; a blocking write would
   // let later statements in the same edge see the new value and break the old-count addressing.
   always_ff @(posedge clock) begin
      if (!nreset) begin
         state    <= IDLE;
         address  <= '0;
         data_out <= '0;
         count    <= '0;
         mybest_q <= '0;
         wr_en    <= 1'b0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (state == DONE)
                  done <= 1'b1;
               if (start_collect) begin
                  mybest_q <= mybest;
                  count    <= '0;
                  overflow <= 1'b0;
                  done     <= 1'b0;
                  state    <= COLLECT;
               end
            end
            COLLECT: begin
               if (nbr_valid) begin
                  if (qualify) begin
                     if (count < MAX_CNT) begin
                        wr_en    <= 1'b1;
                        address  <= TABLE_BASE + STRIDE_W * count;
                        data_out <= nbr_id;
                        count    <= count + ONE;
                     end else begin
                        overflow <= 1'b1;
                     end
                  end
                  if (nbr_last)
                     state <= WRITE_COUNT;
               end
            end
            WRITE_COUNT: begin
               wr_en    <= 1'b1;
               address  <= COUNT_ADDR;
               data_out <= count;
               state    <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
